// File: rtl/eth_tx_pkt_buf.sv
// Store-and-forward Ethernet TX packet buffer: commits whole packets, then replays them with an inter-packet gap.
// Define ETH_TX_PKT_BUF_STATS_EN to build the Tx_Pkt_Count / Drop_Count statistics counters.
module eth_tx_pkt_buf #(
  parameter int unsigned pDepth      = 2048,
  parameter int unsigned pGap_Cycles = 24
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [9:0]  In_Byte,
  input  logic        In_Byte_Valid,
  output logic [9:0]  Eth_Byte,
  output logic        Eth_Byte_Valid,
  output logic        Pkt_Drop,
  output logic        Buf_Empty,
  output logic [15:0] Tx_Pkt_Count,
  output logic [15:0] Drop_Count
);

  localparam int unsigned AW      = $clog2(pDepth);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned GAP_LEN = (pGap_Cycles < 1) ? 1 : pGap_Cycles;
  localparam int unsigned GW      = $clog2(GAP_LEN + 1);

  typedef enum logic {WAIT_SOP, IN_PKT} wr_state_t;
  typedef enum logic [1:0] {IDLE, READ, GAP} rd_state_t;

  wr_state_t       r_wr_state, w_wr_nxt;
  rd_state_t       r_rd_state, w_rd_nxt;
  logic [9:0]      r_mem [pDepth];
  logic [AW-1:0]   r_wr_ptr, r_start_ptr, r_rd_ptr;
  logic [AW-1:0]   w_wr_ptr_nxt, w_start_nxt, w_base, w_waddr;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_avail;
  logic [GW-1:0]   r_gap_cnt, w_gap_nxt;
  logic [9:0]      r_rd_data, r_eth_byte, w_mem_rd;
  logic            r_rd_vld, r_eth_vld, r_pkt_drop, r_buf_empty;
  logic            w_sop, w_eop, w_full, w_we, w_drop, w_commit, w_rd_en, w_eop_out;

  assign w_sop     = In_Byte[9];
  assign w_eop     = In_Byte[8];
  assign w_mem_rd  = r_mem[r_rd_ptr];
  assign w_eop_out = r_rd_vld & r_rd_data[8];
  // An EOP already read but not yet emitted must not count as a waiting packet
  assign w_cnt_avail = r_cnt - CW'(w_eop_out);
  assign w_cnt_nxt   = r_cnt + CW'(w_commit) - CW'(w_eop_out);

  // Write side: SOP restarts at the packet start, a full buffer rewinds the open packet
  always_comb begin
    w_wr_nxt     = r_wr_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_start_nxt  = r_start_ptr;
    w_we         = 1'b0;
    w_drop       = 1'b0;
    w_commit     = 1'b0;
    w_base       = (r_wr_state == IN_PKT && w_sop) ? r_start_ptr : r_wr_ptr;
    w_waddr      = w_base;
    w_full       = (w_base + AW'(1)) == r_rd_ptr;
    if (In_Byte_Valid && (r_wr_state == IN_PKT || w_sop)) begin
      if (r_wr_state == IN_PKT && w_sop) begin
        w_drop = 1'b1;
      end
      if (w_full) begin
        w_drop       = 1'b1;
        w_wr_ptr_nxt = (r_wr_state == IN_PKT) ? r_start_ptr : r_wr_ptr;
        w_wr_nxt     = WAIT_SOP;
      end else begin
        w_we         = 1'b1;
        w_wr_ptr_nxt = w_base + AW'(1);
        if (w_sop) begin
          w_start_nxt = w_base;
        end
        if (w_eop) begin
          w_commit = 1'b1;
          w_wr_nxt = WAIT_SOP;
        end else begin
          w_wr_nxt = IN_PKT;
        end
      end
    end
  end

  // Read side: stream one committed packet, then hold off for the gap
  always_comb begin
    w_rd_nxt  = r_rd_state;
    w_rd_en   = 1'b0;
    w_gap_nxt = r_gap_cnt;
    case (r_rd_state)
      IDLE: begin
        if (w_cnt_avail != '0) begin
          w_rd_nxt = READ;
        end
      end
      READ: begin
        w_rd_en = 1'b1;
        if (w_mem_rd[8]) begin
          w_rd_nxt  = GAP;
          w_gap_nxt = '0;
        end
      end
      GAP: begin
        if (r_gap_cnt == GW'(GAP_LEN - 1)) begin
          w_rd_nxt = (w_cnt_avail != '0) ? READ : IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + GW'(1);
        end
      end
      default: w_rd_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_state <= WAIT_SOP;
      r_rd_state <= IDLE;
    end else begin
      r_wr_state <= w_wr_nxt;
      r_rd_state <= w_rd_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= In_Byte;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wr_ptr    <= '0;
      r_start_ptr <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_gap_cnt   <= '0;
      r_rd_data   <= '0;
      r_rd_vld    <= 1'b0;
      r_eth_byte  <= '0;
      r_eth_vld   <= 1'b0;
      r_pkt_drop  <= 1'b0;
      r_buf_empty <= 1'b1;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_start_ptr <= w_start_nxt;
      r_rd_ptr    <= w_rd_en ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_cnt       <= w_cnt_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_rd_data   <= w_rd_en ? w_mem_rd : '0;
      r_rd_vld    <= w_rd_en;
      r_eth_byte  <= r_rd_data;
      r_eth_vld   <= r_rd_vld;
      r_pkt_drop  <= w_drop;
      r_buf_empty <= (w_cnt_nxt == '0);
    end
  end

  assign Eth_Byte       = r_eth_byte;
  assign Eth_Byte_Valid = r_eth_vld;
  assign Pkt_Drop       = r_pkt_drop;
  assign Buf_Empty      = r_buf_empty;

`ifdef ETH_TX_PKT_BUF_STATS_EN
  logic [15:0] r_tx_cnt, r_drop_cnt;

  // Saturating statistics, updated on the same edges as the emitted EOP / Pkt_Drop
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_tx_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_eop_out && r_tx_cnt != 16'hFFFF) begin
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end
      if (w_drop && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign Tx_Pkt_Count = r_tx_cnt;
  assign Drop_Count   = r_drop_cnt;
`else
  assign Tx_Pkt_Count = 16'd0;
  assign Drop_Count   = 16'd0;
`endif

endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// Directed bench for eth_tx_pkt_buf: a default-depth instance and a 64-byte instance share clock, reset and input byte.
module tb_eth_tx_pkt_buf;

`ifdef ETH_TX_PKT_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  in_byte = '0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [9:0]  eb0, eb1;
  logic        ev0, ev1, drop0, drop1, empty0, empty1;
  logic [15:0] tx0, tx1, dc0, dc1;

  eth_tx_pkt_buf dut (
    .Clk(clk), .Rst(rst), .In_Byte(in_byte), .In_Byte_Valid(v0),
    .Eth_Byte(eb0), .Eth_Byte_Valid(ev0), .Pkt_Drop(drop0), .Buf_Empty(empty0),
    .Tx_Pkt_Count(tx0), .Drop_Count(dc0)
  );

  eth_tx_pkt_buf #(.pDepth(64)) dut_s (
    .Clk(clk), .Rst(rst), .In_Byte(in_byte), .In_Byte_Valid(v1),
    .Eth_Byte(eb1), .Eth_Byte_Valid(ev1), .Pkt_Drop(drop1), .Buf_Empty(empty1),
    .Tx_Pkt_Count(tx1), .Drop_Count(dc1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: logs every valid byte with its cycle, counts drop pulses
  logic [9:0] q0[$], q1[$];
  int         c0[$], c1[$];
  int         drops0 = 0, drops1 = 0, dcyc1 = -1, zviol = 0;
  always @(negedge clk) begin
    if (ev0) begin q0.push_back(eb0); c0.push_back(cyc); end
    else if (eb0 != 10'd0) zviol++;
    if (ev1) begin q1.push_back(eb1); c1.push_back(cyc); end
    else if (eb1 != 10'd0) zviol++;
    if (drop0) drops0++;
    if (drop1) begin drops1++; dcyc1 = cyc; end
  end

  int n_vec = 0, n_err = 0;
  logic [9:0] e0[$], e1[$];
  int rb0 = 0, rb1 = 0, xb0 = 0, xb1 = 0;
  int acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] b, input bit sm);
    step();
    in_byte = b;
    v0 = !sm;
    v1 = sm;
    acc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      v0 = 1'b0;
      v1 = 1'b0;
    end
  endtask

  function automatic logic [9:0] mk(input int i, input int n, input int seed);
    logic [7:0] d;
    d = 8'(i * 7 + seed);
    return {i == 0, i == n - 1, d};
  endfunction

  task automatic send(input int n, input int seed, input bit sm);
    for (int i = 0; i < n; i++) begin
      wr(mk(i, n, seed), sm);
      if (sm) e1.push_back(mk(i, n, seed));
      else    e0.push_back(mk(i, n, seed));
    end
    idle(1);
  endtask

  task automatic wait_q(input bit sm, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (((sm ? q1.size() - rb1 : q0.size() - rb0) < n) && k < budget) begin
      step();
      k++;
    end
    chk(tag, sm ? q1.size() - rb1 : q0.size() - rb0, n);
  endtask

  // Compare everything received since the last compare against everything expected since then
  task automatic cmp(input bit sm, input string tag);
    int ng, ne;
    ng = sm ? q1.size() - rb1 : q0.size() - rb0;
    ne = sm ? e1.size() - xb1 : e0.size() - xb0;
    chk({tag, "_len"}, ng, ne);
    for (int i = 0; i < ng && i < ne; i++) begin
      if (sm) chk(tag, q1[rb1 + i], e1[xb1 + i]);
      else    chk(tag, q0[rb0 + i], e0[xb0 + i]);
    end
    if (sm) begin rb1 = q1.size(); xb1 = e1.size(); end
    else    begin rb0 = q0.size(); xb0 = e0.size(); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int eop_acc, a63, emp_bad, d0;

    // Reset state
    idle(3);
    chk("rst_valid", ev0, 0);
    chk("rst_byte", eb0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_drop", drop0, 0);
    chk("rst_tx_cnt", tx0, 0);
    chk("rst_drop_cnt", dc0, 0);
    chk("rst_empty_s", empty1, 1);
    rst = 1'b0;
    idle(2);

    // 64-byte packet with idle cycles between bytes
    for (int i = 0; i < 64; i++) begin
      wr(mk(i, 64, 3), 1'b0);
      e0.push_back(mk(i, 64, 3));
      idle(1);
      if (i == 32) chk("empty_open_pkt", empty0, 1);
    end
    eop_acc = acc;
    chk("empty_committed", empty0, 0);
    wait_q(1'b0, 64, 300, "t1_timeout");
    if (q0.size() - rb0 >= 64) begin
      chk("t1_latency", c0[rb0] - eop_acc, 3);
      chk("t1_contiguous", c0[rb0 + 63] - c0[rb0], 63);
    end
    cmp(1'b0, "t1_data");
    idle(30);
    chk("t1_empty_after", empty0, 1);

    // Two 60-byte packets back to back
    send(60, 11, 1'b0);
    e0.pop_back();
    e0.push_back(mk(59, 60, 11));
    for (int i = 0; i < 60; i++) begin
      wr(mk(i, 60, 61), 1'b0);
      e0.push_back(mk(i, 60, 61));
    end
    idle(1);
    wait_q(1'b0, 120, 500, "t2_timeout");
    if (q0.size() - rb0 >= 120) begin
      chk("t2_gap", c0[rb0 + 60] - c0[rb0 + 59] - 1, 24);
      chk("t2_pkt0_contig", c0[rb0 + 59] - c0[rb0], 59);
      chk("t2_pkt1_contig", c0[rb0 + 119] - c0[rb0 + 60], 59);
    end
    cmp(1'b0, "t2_data");
    idle(30);

    // Open packet superseded by a new SOP
    d0 = drops0;
    for (int i = 0; i < 10; i++) begin
      wr({i == 0, 1'b0, 8'(i + 200)}, 1'b0);
    end
    send(21, 99, 1'b0);
    wait_q(1'b0, 21, 200, "t3_timeout");
    idle(30);
    chk("t3_drop_pulses", drops0 - d0, 1);
    cmp(1'b0, "t3_data");
    chk("t3_drop_count", dc0, STATS ? 1 : 0);
    chk("t3_tx_count", tx0, STATS ? 4 : 0);

    // 64-byte buffer: advance pointers to 60, overflow, then a packet across the wrap
    send(60, 5, 1'b1);
    wait_q(1'b1, 60, 300, "t4_pre_timeout");
    idle(30);
    cmp(1'b1, "t4_pre_data");
    emp_bad = 0;
    a63 = 0;
    for (int i = 0; i < 70; i++) begin
      wr(mk(i, 70, 17), 1'b1);
      if (i == 63) a63 = acc;
      if (empty1 !== 1'b1) emp_bad++;
    end
    idle(40);
    if (empty1 !== 1'b1) emp_bad++;
    chk("t4_drop_pulses", drops1, 1);
    chk("t4_drop_at_byte64", dcyc1, a63);
    chk("t4_no_output", q1.size() - rb1, 0);
    chk("t4_empty_held", emp_bad, 0);
    send(10, 77, 1'b1);
    wait_q(1'b1, 10, 200, "t4_wrap_timeout");
    idle(30);
    cmp(1'b1, "t4_wrap_data");
    chk("t4_drop_count", dc1, STATS ? 1 : 0);
    chk("t4_tx_count", tx1, STATS ? 2 : 0);

    // Reset during output byte 5 of 40
    for (int i = 0; i < 40; i++) begin
      wr(mk(i, 40, 33), 1'b0);
    end
    idle(1);
    wait_q(1'b0, 5, 200, "t5_timeout");
    rst = 1'b1;
    step();
    chk("t5_valid_after_rst", ev0, 0);
    chk("t5_byte_after_rst", eb0, 0);
    chk("t5_empty_after_rst", empty0, 1);
    rst = 1'b0;
    idle(60);
    chk("t5_no_more_output", q0.size() - rb0, 5);
    chk("t5_tx_count_rst", tx0, 0);
    rb0 = q0.size();
    wr(10'h3A5, 1'b0);
    e0.push_back(10'h3A5);
    idle(1);
    wait_q(1'b0, 1, 50, "t5_one_byte_timeout");
    idle(30);
    cmp(1'b0, "t5_one_byte");
    chk("t5_tx_count", tx0, STATS ? 1 : 0);

    chk("zero_when_idle", zviol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_tx_pkt_buf.md
ETH_TX_PKT_BUF -- requirements
Module: eth_tx_pkt_buf

Interface
REQ-001 The module SHALL have parameter pDepth, default 2048, byte capacity of the storage RAM (power of two, >= 64); usable capacity pDepth-1.
REQ-002 The module SHALL have parameter pGap_Cycles, default 24, minimum idle Eth_Clk cycles between the EOP of one output packet and the SOP of the next.
REQ-003 Port Clk  input  1  single clock, Eth_Clk domain; all logic on rising edge.
REQ-004 Port Rst  input  1  synchronous reset, active-high.
REQ-005 Port In_Byte  input  10  write byte: bit9 SOP, bit8 EOP, [7:0] payload.
REQ-006 Port In_Byte_Valid  input  1  In_Byte is written this cycle; bytes may arrive on non-consecutive cycles.
REQ-007 Port Eth_Byte  output  10  read byte to eth_tx, same bit layout as In_Byte.
REQ-008 Port Eth_Byte_Valid  output  1  Eth_Byte valid; asserted on consecutive cycles for the whole packet.
REQ-009 Port Pkt_Drop  output  1  one-cycle pulse when an input packet is discarded.
REQ-010 Port Buf_Empty  output  1  high when no committed packet is stored.
REQ-011 Port Tx_Pkt_Count  output  16  packets fully sent (statistics build only).
REQ-012 Port Drop_Count  output  16  packets dropped (statistics build only).

Function
REQ-013 Store-and-forward: output of a packet SHALL NOT start until its EOP byte is written (committed).
REQ-014 Write side states SHALL be WAIT_SOP and IN_PKT; in WAIT_SOP, valid bytes without SOP are discarded silently (no Pkt_Drop).
REQ-015 A valid SOP byte SHALL record start pointer, write the byte, and enter IN_PKT; a byte with SOP and EOP both set is a complete 1-byte packet, committed immediately.
REQ-016 In IN_PKT a byte with EOP SHALL be written, commit pointer set to write pointer+1, committed-packet count incremented, return to WAIT_SOP.
REQ-017 A SOP in IN_PKT SHALL discard the open packet (write pointer rewound to start, Pkt_Drop pulse) and start a new packet with that byte in the same cycle.
REQ-018 A write that would make write pointer equal read pointer (full) SHALL discard the open packet: rewind, Pkt_Drop pulse, enter WAIT_SOP; the offending byte is not stored.
REQ-019 Pointers SHALL be log2(pDepth) bits and wrap modulo pDepth; packets may straddle the wrap.
REQ-020 Read side states SHALL be IDLE, READ, GAP; IDLE->READ when committed count > 0; READ emits one byte per cycle with Eth_Byte_Valid high, no bubbles, until the stored EOP byte; then GAP for exactly pGap_Cycles cycles, then IDLE.
REQ-021 With read side IDLE, the first output byte SHALL be valid exactly 3 cycles after the clock edge that accepted the EOP byte.
REQ-022 Output bytes SHALL equal the stored 10-bit values; Eth_Byte SHALL be 0 when Eth_Byte_Valid is low.
REQ-023 Committed count decrements on the edge emitting an EOP; simultaneous increment and decrement SHALL leave it unchanged.
REQ-024 Buf_Empty SHALL equal (committed count == 0) registered; an open uncommitted packet does not clear it.

Reset
REQ-025 On Rst high at a clock edge: pointers, committed count, gap counter = 0; write side WAIT_SOP; read side IDLE; Eth_Byte=0, Eth_Byte_Valid=0, Pkt_Drop=0, Buf_Empty=1, counters=0.
REQ-026 Rst asserted mid-packet (input or output) SHALL abandon all stored data; Eth_Byte_Valid low in the first cycle after the reset edge, no EOP emitted.

Configuration
REQ-027 Macro ETH_TX_PKT_BUF_STATS_EN defined: Tx_Pkt_Count increments per emitted EOP, Drop_Count per Pkt_Drop, both saturate at 0xFFFF.
REQ-028 Macro undefined: counter logic SHALL be absent and Tx_Pkt_Count, Drop_Count tied to 0; all other behaviour identical.

Verification
REQ-029 64-byte packet (SOP on byte 0, EOP on byte 63) written with one idle cycle between bytes -> 64 consecutive valid output cycles, identical data, first valid 3 cycles after EOP edge.
REQ-030 Two 60-byte packets back-to-back, pGap_Cycles=24 -> exactly 24 invalid cycles between first EOP and second SOP at output.
REQ-031 SOP, 10 bytes, then new SOP+20 bytes+EOP -> one Pkt_Drop pulse; output only the 21-byte packet; Drop_Count=1 (stats build).
REQ-032 pDepth=64, 70-byte packet with output stalled by prior traffic absent -> Pkt_Drop on byte 64, nothing output, Buf_Empty stays 1; next 10-byte packet output correctly across pointer wrap.
REQ-033 Rst pulsed during output byte 5 of 40 -> Eth_Byte_Valid low next cycle, Buf_Empty=1, a following 1-byte SOP+EOP packet is output as single cycle with bits 9 and 8 set.
